seg_display_scanner: RTL and testbench

Parametrised multiplexed seven-segment scanner. It is the successor to the fixed two-by-four-digit display driver that sits beside top_level on the board wrapper. The block latches a packed hex value on a load strobe and time-multiplexes it across NUM_DIGITS common-anode digits. Over the previous driver it adds anti-ghost blanking, a brightness duty-cycle control, per-digit decimal points, leading-zero suppression and a frame-done pulse.

---
 rtl/seg_display_pkg.sv | 24 ++
 rtl/hex_to_7seg.sv | 10 +
 rtl/seg_display_scanner.sv | 131 +++++++++++++
 tb/tb_seg_display_scanner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Entry 15 first so that SEG_TABLE[n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    import seg_display_pkg::*;

    assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_display_scanner.sv
// Multiplexed seven-segment scanner with blanking, dimming,
// decimal points, leading-zero suppression and frame pulse.
module seg_display_scanner #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_BITS = 3,
    parameter int BLANK_CYC   = 16
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [4*NUM_DIGITS-1:0] Value,
    input  logic [NUM_DIGITS-1:0]   DpIn,
    input  logic                    Load,
    input  logic                    LzbEn,
    input  logic [BRIGHT_BITS-1:0]  Brightness,
    output logic [NUM_DIGITS-1:0]   en_out,
    output logic [6:0]              out7,
    output logic                    dp_out,
    output logic                    frame_done
);
    import seg_display_pkg::*;

    localparam int CW = (clog2(REFRESH_DIV) < 1) ? 1 : clog2(REFRESH_DIV);
    localparam int IW = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS);
    localparam int LW = clog2(REFRESH_DIV) + BRIGHT_BITS + 1;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] val_q, val_eff;
    logic [NUM_DIGITS-1:0]   dps_q, dp_eff;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dpo_q, dpo_d;
    logic                    fd_q, fd_d;

    logic [LW-1:0]           on_limit;
    logic [NUM_DIGITS-1:0]   supp;
    logic                    allz;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_supp;
    logic [6:0]              cur_seg;
    logic                    lit;
    logic                    wrap;
    logic                    last;

    // A load is forwarded so the capturing edge already shows the new data.
    assign val_eff = Load ? Value : val_q;
    assign dp_eff  = Load ? DpIn : dps_q;

    assign on_limit = ((LW'(Brightness) + LW'(1)) * LW'(REFRESH_DIV))
                      >> BRIGHT_BITS;

    always_comb begin
        allz     = 1'b1;
        supp     = '0;
        cur_nib  = '0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            allz    = allz & (val_eff[4*k +: 4] == 4'h0);
            supp[k] = LzbEn & allz & (k != 0);
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib  = val_eff[4*k +: 4];
                cur_dp   = dp_eff[k];
                cur_supp = supp[k];
            end
        end
    end

    hex_to_7seg u_hex (
        .hex_i (cur_nib),
        .seg_o (cur_seg)
    );

    assign wrap = (cnt_q == CW'(REFRESH_DIV - 1));
    assign last = (idx_q == IW'(NUM_DIGITS - 1));
    assign lit  = (LW'(cnt_q) >= LW'(BLANK_CYC))
                  && (LW'(cnt_q) < on_limit)
                  && !cur_supp;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        fd_d  = wrap && last;
        en_d  = '1;
        seg_d = SEG_OFF;
        dpo_d = 1'b1;
        if (wrap) begin
            cnt_d = '0;
            idx_d = last ? '0 : idx_q + IW'(1);
        end
        if (lit) begin
            en_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = cur_seg;
            dpo_d = ~cur_dp;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
            idx_q <= '0;
            val_q <= '0;
            dps_q <= '0;
            en_q  <= '1;
            seg_q <= SEG_OFF;
            dpo_q <= 1'b1;
            fd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            en_q  <= en_d;
            seg_q <= seg_d;
            dpo_q <= dpo_d;
            fd_q  <= fd_d;
            if (Load) begin
                val_q <= Value;
                dps_q <= DpIn;
            end
        end
    end

    assign en_out     = en_q;
    assign out7       = seg_q;
    assign dp_out     = dpo_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Randomised bench for seg_display_scanner against a cycle-count
// reference model of the scan sequence.
module tb_seg_display_scanner;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int B  = 2;
    localparam int BL = 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic [15:0]   Value = '0;
    logic [3:0]    DpIn = '0;
    logic          Load = 1'b0;
    logic          LzbEn = 1'b0;
    logic [1:0]    Brightness = '0;
    logic [3:0]    en_out;
    logic [6:0]    out7;
    logic          dp_out;
    logic          frame_done;

    int checks = 0;
    int failures = 0;

    int          p;
    logic [15:0] mval;
    logic [3:0]  mdp;

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_display_scanner #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (R),
        .BRIGHT_BITS (B),
        .BLANK_CYC   (BL)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Value      (Value),
        .DpIn       (DpIn),
        .Load       (Load),
        .LzbEn      (LzbEn),
        .Brightness (Brightness),
        .en_out     (en_out),
        .out7       (out7),
        .dp_out     (dp_out),
        .frame_done (frame_done)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (p=%0d)", tag, got, exp, p);
        end
    endtask

    // One clock: model captures, advances position, checks all outputs.
    task automatic tick();
        logic        ld, lz, sup, lit;
        logic [15:0] v;
        logic [3:0]  d, e_en;
        logic [6:0]  e_seg;
        logic        e_dp, e_fd;
        int          br, cnt, idx, onl, nib;
        ld = Load; v = Value; d = DpIn;
        lz = LzbEn; br = int'(Brightness);
        @(posedge Clk);
        if (ld) begin
            mval = v;
            mdp  = d;
        end
        cnt = p % R;
        idx = (p / R) % N;
        p++;
        onl = ((br + 1) * R) >> B;
        sup = lz && (idx != 0) && ((mval >> (4 * idx)) == 16'h0);
        lit = (cnt >= BL) && (cnt < onl) && !sup;
        nib = int'((mval >> (4 * idx)) & 16'hF);
        e_en  = lit ? (~(4'b0001 << idx)) : 4'hF;
        e_seg = lit ? seg_ref[nib] : 7'h7F;
        e_dp  = lit ? ~mdp[idx] : 1'b1;
        e_fd  = (p % (R * N)) == 0;
        #1;
        check("en_out", 32'(en_out), 32'(e_en));
        check("out7", 32'(out7), 32'(e_seg));
        check("dp_out", 32'(dp_out), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        Value = v;
        DpIn  = d;
        Load  = 1'b1;
        tick();
        Load  = 1'b0;
    endtask

    initial begin
        int fd_cnt;
        p = 0;
        mval = '0;
        mdp = '0;

        Rst = 1'b0;
        Value = 16'h1234;
        Load = 1'b1;
        Brightness = 2'd3;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_en", 32'(en_out), 32'hF);
        check("rst_seg", 32'(out7), 32'h7F);
        check("rst_dp", 32'(dp_out), 32'h1);
        check("rst_fd", 32'(frame_done), 32'h0);
        @(negedge Clk);
        Load = 1'b0;
        Rst = 1'b1;
        ticks(32);

        LzbEn = 1'b0;
        load(16'h1234, 4'h0);
        fd_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (frame_done) fd_cnt++;
        end
        check("fd_per_64", 32'(fd_cnt), 32'd2);

        Brightness = 2'd0;
        ticks(32);

        Brightness = 2'd3;
        LzbEn = 1'b1;
        load(16'h00A0, 4'h0);
        ticks(32);
        load(16'h0000, 4'h0);
        ticks(32);

        LzbEn = 1'b0;
        load(16'hFFFF, 4'b0100);
        ticks(32);

        for (int i = 0; i < R && (p % R) != 4; i++) tick();
        check("midload_pos", 32'(p % R), 32'd4);
        Value = 16'h8888;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        check("midload_seg", 32'(out7), 32'h00);
        ticks(8);

        for (int i = 0; i < R * N && !((p % R) == 5 && ((p / R) % N) == 2); i++)
            tick();
        check("rst_pos", 32'(p % (R * N)), 32'd21);
        #2;
        Rst = 1'b0;
        #1;
        check("async_en", 32'(en_out), 32'hF);
        check("async_seg", 32'(out7), 32'h7F);
        check("async_dp", 32'(dp_out), 32'h1);
        check("async_fd", 32'(frame_done), 32'h0);
        @(negedge Clk);
        Rst = 1'b1;
        p = 0;
        mval = '0;
        mdp = '0;
        tick();
        tick();
        check("restart_en", 32'(en_out), 32'hE);
        ticks(30);

        for (int i = 0; i < 640; i++) begin
            logic [15:0] v;
            for (int k = 0; k < 4; k++)
                v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0
                              : 4'($urandom_range(0, 15));
            Value = v;
            DpIn = 4'($urandom_range(0, 15));
            Load = ($urandom_range(0, 7) == 0);
            if ((i % 16) == 0) begin
                Brightness = 2'($urandom_range(0, 3));
                LzbEn = 1'($urandom_range(0, 1));
            end
            tick();
        end
        Load = 1'b0;
        ticks(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
